// File: rtl/dsky_serial_in_pkg.sv
// dsky_serial_in_pkg: shared states, field IDs and packet constants for the DSKY serial input
package dsky_serial_in_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      P_HUNT,
      P_ID,
      P_HI,
      P_LO,
      P_CSUM
   } parser_state_t;

   typedef enum logic [2:0] {
      F_VERB    = 3'd0,
      F_NOUN    = 3'd1,
      F_TIME    = 3'd2,
      F_APOGEE  = 3'd3,
      F_PERIGEE = 3'd4
   } field_id_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   function automatic logic [7:0] packet_csum(input logic [7:0] id, input logic [7:0] hi, input logic [7:0] lo);
      return id ^ hi ^ lo;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver with input synchronizer, glitch rejection and framing check
module uart_rx_byte
   import dsky_serial_in_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   logic          rx_meta, rx_sync, rx_prev;
   rx_state_t     state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    bit_idx, bit_nx;
   logic [7:0]    shift, shift_nx;
   logic          valid_nx, ferr_nx;

   assign byte_data = shift;

   // Two-flop synchronizer plus one delayed copy for falling-edge detection; all idle high.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Receiver state, baud/bit counters, shift register and one-cycle result pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= RX_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         bit_idx    <= bit_nx;
         shift      <= shift_nx;
         byte_valid <= valid_nx;
         frame_err  <= ferr_nx;
      end
   end

   // Start is re-checked at mid-bit so short lows are dropped; later samples land one bit apart.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 1'b1;
      bit_nx   = bit_idx;
      shift_nx = shift;
      valid_nx = 1'b0;
      ferr_nx  = 1'b0;
      case (state)
         RX_IDLE: begin
            cnt_nx = '0;
            if (rx_prev && !rx_sync) state_nx = RX_START;
         end
         RX_START: begin
            if (cnt == HALF) begin
               cnt_nx   = '0;
               bit_nx   = '0;
               state_nx = rx_sync ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt == FULL) begin
               cnt_nx   = '0;
               shift_nx = {rx_sync, shift[7:1]};
               if (bit_idx == 3'd7) state_nx = RX_STOP;
               else bit_nx = bit_idx + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt == FULL) begin
               cnt_nx   = '0;
               valid_nx = rx_sync;
               ferr_nx  = !rx_sync;
               state_nx = RX_IDLE;
            end
         end
         default: state_nx = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/dsky_serial_in.sv
// dsky_serial_in: receives checksummed telemetry packets over UART and updates five DSKY/AXI value registers
module dsky_serial_in
   import dsky_serial_in_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        rx,
   output logic [14:0] DSKY_VERB_data,
   output logic [14:0] DSKY_NOUN_data,
   output logic [14:0] AXI_MISSION_TIME_data,
   output logic [14:0] AXI_APOGEE_data,
   output logic [14:0] AXI_PERIGEE_data,
   output logic [4:0]  update,
   output logic        err
);

   logic          byte_valid, frame_err;
   logic [7:0]    byte_data;
   parser_state_t state, state_nx;
   logic [7:0]    id_q, hi_q, lo_q;
   logic [4:0]    upd_nx;
   logic          err_nx;
   logic [14:0]   value;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clock      (clock),
      .reset_n    (reset_n),
      .rx         (rx),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (frame_err)
   );

   assign value = {hi_q[6:0], lo_q};

   // Parser state register and registered update/err pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= P_HUNT;
         update <= '0;
         err    <= 1'b0;
      end else begin
         state  <= state_nx;
         update <= upd_nx;
         err    <= err_nx;
      end
   end

   // Latch ID/HI/LO as they arrive so the checksum and value are ready at the CSUM byte.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         id_q <= '0;
         hi_q <= '0;
         lo_q <= '0;
      end else if (byte_valid) begin
         if (state == P_ID) id_q <= byte_data;
         if (state == P_HI) hi_q <= byte_data;
         if (state == P_LO) lo_q <= byte_data;
      end
   end

   // Packet parser: sync is only searched for in HUNT, so 0xA5 elsewhere is plain data.
   always_comb begin
      state_nx = state;
      upd_nx   = '0;
      err_nx   = frame_err;
      if (frame_err) state_nx = P_HUNT;
      else if (byte_valid) begin
         case (state)
            P_HUNT: if (byte_data == SYNC_BYTE) state_nx = P_ID;
            P_ID: begin
               state_nx = (byte_data <= 8'd4) ? P_HI : P_HUNT;
               err_nx   = byte_data > 8'd4;
            end
            P_HI: begin
               state_nx = byte_data[7] ? P_HUNT : P_LO;
               err_nx   = byte_data[7];
            end
            P_LO: state_nx = P_CSUM;
            P_CSUM: begin
               state_nx = P_HUNT;
               if (byte_data == packet_csum(id_q, hi_q, lo_q)) upd_nx = 5'b00001 << id_q[2:0];
               else err_nx = 1'b1;
            end
            default: state_nx = P_HUNT;
         endcase
      end
   end

   // Register file: a field changes only together with its update pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         DSKY_VERB_data        <= '0;
         DSKY_NOUN_data        <= '0;
         AXI_MISSION_TIME_data <= '0;
         AXI_APOGEE_data       <= '0;
         AXI_PERIGEE_data      <= '0;
      end else begin
         if (upd_nx[F_VERB])    DSKY_VERB_data        <= value;
         if (upd_nx[F_NOUN])    DSKY_NOUN_data        <= value;
         if (upd_nx[F_TIME])    AXI_MISSION_TIME_data <= value;
         if (upd_nx[F_APOGEE])  AXI_APOGEE_data       <= value;
         if (upd_nx[F_PERIGEE]) AXI_PERIGEE_data      <= value;
      end
   end

endmodule

// File: tb/tb_dsky_serial_in.sv
// tb_dsky_serial_in: directed packet vectors and corner-case sequences for dsky_serial_in
module tb_dsky_serial_in;

   localparam int CPB = 8;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx = 1'b1;
   logic [14:0] verb, noun, mtime, apogee, perigee;
   logic [4:0]  update;
   logic        err;

   int checks = 0;
   int errors = 0;
   int tot_upd = 0;
   int tot_err = 0;
   int viol = 0;
   logic [4:0] last_upd = '0;

   typedef struct packed {
      logic [2:0]  n;
      logic [47:0] b;
      logic [4:0]  upd;
      logic [14:0] val;
      logic [1:0]  errs;
   } vec_t;

   vec_t vecs [10];
   logic [14:0] m [5];

   dsky_serial_in #(.CLKS_PER_BIT(CPB)) dut (
      .clock                 (clock),
      .reset_n               (reset_n),
      .rx                    (rx),
      .DSKY_VERB_data        (verb),
      .DSKY_NOUN_data        (noun),
      .AXI_MISSION_TIME_data (mtime),
      .AXI_APOGEE_data       (apogee),
      .AXI_PERIGEE_data      (perigee),
      .update                (update),
      .err                   (err)
   );

   always #5 clock = ~clock;

   // Pulse monitor sampled on the falling edge, away from the active edge.
   always @(negedge clock) begin
      if (update != 5'd0) begin
         tot_upd++;
         last_upd = update;
      end
      if (err) tot_err++;
      if ((err && update != 5'd0) || !$onehot0(update)) viol++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         repeat (CPB) @(negedge clock);
      end
   endtask

   task automatic check_regs(input string tag);
      chk({tag, " verb"}, 32'(verb), 32'(m[0]));
      chk({tag, " noun"}, 32'(noun), 32'(m[1]));
      chk({tag, " time"}, 32'(mtime), 32'(m[2]));
      chk({tag, " apogee"}, 32'(apogee), 32'(m[3]));
      chk({tag, " perigee"}, 32'(perigee), 32'(m[4]));
   endtask

   initial begin
      int e0, u0;
      vecs[0] = '{3'd5, 48'hA5_01_00_25_24_00, 5'b00010, 15'h0025, 2'd0};
      vecs[1] = '{3'd5, 48'hA5_02_7F_FF_82_00, 5'b00100, 15'h7FFF, 2'd0};
      vecs[2] = '{3'd5, 48'hA5_00_00_37_37_00, 5'b00001, 15'h0037, 2'd0};
      vecs[3] = '{3'd5, 48'hA5_03_00_10_00_00, 5'b00000, 15'h0000, 2'd1};
      vecs[4] = '{3'd2, 48'hA5_07_00_00_00_00, 5'b00000, 15'h0000, 2'd1};
      vecs[5] = '{3'd5, 48'hA5_04_01_02_07_00, 5'b10000, 15'h0102, 2'd0};
      vecs[6] = '{3'd5, 48'hA5_03_00_A5_A6_00, 5'b01000, 15'h00A5, 2'd0};
      vecs[7] = '{3'd6, 48'h12_A5_01_01_22_22, 5'b00010, 15'h0122, 2'd0};
      vecs[8] = '{3'd5, 48'hA5_00_25_80_A5_00, 5'b00001, 15'h2580, 2'd0};
      vecs[9] = '{3'd3, 48'hA5_01_80_00_00_00, 5'b00000, 15'h0000, 2'd1};
      for (int k = 0; k < 5; k++) m[k] = '0;

      repeat (3) @(negedge clock);
      check_regs("reset");
      chk("reset update", 32'(update), 32'd0);
      chk("reset err", 32'(err), 32'd0);
      reset_n = 1'b1;
      repeat (5) @(negedge clock);

      for (int i = 0; i < 10; i++) begin
         e0 = tot_err;
         u0 = tot_upd;
         for (int j = 0; j < int'(vecs[i].n); j++) send_byte(vecs[i].b[47-8*j -: 8], 1'b1);
         repeat (20) @(negedge clock);
         for (int k = 0; k < 5; k++) if (vecs[i].upd[k]) m[k] = vecs[i].val;
         chk($sformatf("vec%0d update count", i), 32'(tot_upd - u0), (vecs[i].upd != 5'd0) ? 32'd1 : 32'd0);
         if (vecs[i].upd != 5'd0) chk($sformatf("vec%0d update bits", i), 32'(last_upd), 32'(vecs[i].upd));
         chk($sformatf("vec%0d err count", i), 32'(tot_err - e0), 32'(vecs[i].errs));
         check_regs($sformatf("vec%0d", i));
      end

      // Stop bit low after A5 01: error, and the remaining bytes must be discarded from HUNT.
      e0 = tot_err;
      u0 = tot_upd;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b0);
      rx = 1'b1;
      repeat (16) @(negedge clock);
      send_byte(8'h00, 1'b1);
      send_byte(8'h25, 1'b1);
      send_byte(8'h24, 1'b1);
      repeat (20) @(negedge clock);
      chk("stop0 err count", 32'(tot_err - e0), 32'd1);
      chk("stop0 update count", 32'(tot_upd - u0), 32'd0);
      check_regs("stop0");

      // 3-cycle glitch between sync and ID must not inject a byte or an error.
      e0 = tot_err;
      u0 = tot_upd;
      send_byte(8'hA5, 1'b1);
      rx = 1'b0;
      repeat (3) @(negedge clock);
      rx = 1'b1;
      repeat (100) @(negedge clock);
      chk("glitch err count", 32'(tot_err - e0), 32'd0);
      chk("glitch update count", 32'(tot_upd - u0), 32'd0);
      send_byte(8'h01, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      repeat (20) @(negedge clock);
      m[1] = 15'h0100;
      chk("glitch pkt err count", 32'(tot_err - e0), 32'd0);
      chk("glitch pkt update count", 32'(tot_upd - u0), 32'd1);
      check_regs("glitch pkt");

      // Reset in the middle of the HI byte, then a clean packet.
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      rx = 1'b0;
      repeat (20) @(negedge clock);
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      for (int k = 0; k < 5; k++) m[k] = '0;
      check_regs("midrst");
      chk("midrst update", 32'(update), 32'd0);
      chk("midrst err", 32'(err), 32'd0);
      rx = 1'b1;
      reset_n = 1'b1;
      repeat (20) @(negedge clock);
      e0 = tot_err;
      u0 = tot_upd;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h25, 1'b1);
      send_byte(8'h24, 1'b1);
      repeat (20) @(negedge clock);
      m[1] = 15'h0025;
      chk("postrst update count", 32'(tot_upd - u0), 32'd1);
      chk("postrst update bits", 32'(last_upd), 32'b00010);
      chk("postrst err count", 32'(tot_err - e0), 32'd0);
      check_regs("postrst");

      chk("update/err exclusivity", 32'(viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
